// File: rtl/sobel_pkg.sv
// Shared types and helpers for the Sobel-to-UART transmit path.
package sobel_pkg;

    // Transmit scheduler states: wait for a slot, issue a pixel byte,
    // wait for the slot reserved for the checksum trailer, issue the trailer.
    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        SEND_PIX = 2'd1,
        WAIT_SUM = 2'd2,
        SEND_SUM = 2'd3
    } tx_state_e;

    // Clock cycles reserved per UART byte: 10 bit times (start, 8 data,
    // stop) plus a 2-cycle guard so the transmitter is always idle when
    // the next byte is strobed in.
    function automatic int calc_byte_cycles(input int clk_freq, input int uart_bps);
        return 10 * (clk_freq / uart_bps) + 2;
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with show-ahead read: rd_data presents the head entry
// whenever the FIFO is not empty, and rd_en simply advances past it.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic             clk,
    input  logic             srst,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rd_en,
    output logic [WIDTH-1:0] rd_data,
    output logic             full,
    output logic             empty
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [AW:0]      count_q, count_d;
    logic             do_wr;
    logic             do_rd;

    assign full    = (count_q == (AW+1)'(DEPTH));
    assign empty   = (count_q == '0);
    assign rd_data = mem[rd_ptr_q];

    // A write into a full FIFO is still taken when the head leaves in the
    // same cycle; the slot being overwritten is the one being consumed.
    assign do_wr = wr_en && (!full || rd_en);
    assign do_rd = rd_en && !empty;

    // Pointer and occupancy bookkeeping; DEPTH is a power of two so the
    // pointers wrap naturally.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_wr) begin
            wr_ptr_d = wr_ptr_q + AW'(1);
        end
        if (do_rd) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end
        case ({do_wr, do_rd})
            2'b10:   count_d = count_q + (AW+1)'(1);
            2'b01:   count_d = count_q - (AW+1)'(1);
            default: count_d = count_q;
        endcase
    end

    // Pointer and occupancy registers.
    always_ff @(posedge clk) begin
        if (srst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage array; contents need no reset since occupancy guards reads.
    always_ff @(posedge clk) begin
        if (do_wr) begin
            mem[wr_ptr_q] <= wr_data;
        end
    end

endmodule

// File: rtl/uart_tx_sched.sv
// Paces Sobel result bytes into the UART transmitter and appends a mod-256
// checksum trailer after every frame of FRAME_BYTES results.
module uart_tx_sched
    import sobel_pkg::*;
#(
    parameter int UART_BPS    = 10_000_000,
    parameter int CLK_FREQ    = 50_000_000,
    parameter int FIFO_DEPTH  = 16,
    parameter int FRAME_BYTES = 4
) (
    input  logic       sys_clk,
    input  logic       sys_rst,
    input  logic [7:0] pix_data,
    input  logic       pix_flag,
    output logic [7:0] tx_data,
    output logic       tx_flag,
    output logic       frame_done,
    output logic       overflow
);

    localparam int BYTE_CYCLES = calc_byte_cycles(CLK_FREQ, UART_BPS);
    localparam int GAP_W       = $clog2(BYTE_CYCLES);
    localparam int CNT_W       = $clog2(FRAME_BYTES + 1);

    localparam logic [GAP_W-1:0] GAP_LOAD = GAP_W'(BYTE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FRAME_BYTES - 1);

    tx_state_e        state_q, state_d;
    logic [GAP_W-1:0] gap_cnt_q, gap_cnt_d;
    logic [7:0]       sum_q, sum_d;
    logic [CNT_W-1:0] pix_cnt_q, pix_cnt_d;
    logic [7:0]       tx_data_q, tx_data_d;
    logic             tx_flag_q, tx_flag_d;
    logic             frame_done_q, frame_done_d;
    logic             overflow_q, overflow_d;

    logic             issue_pix;
    logic             issue_sum;
    logic             fifo_rd_en;
    logic [7:0]       fifo_rd_data;
    logic             fifo_full;
    logic             fifo_empty;

    sync_fifo #(
        .WIDTH (8),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (sys_clk),
        .srst    (sys_rst),
        .wr_en   (pix_flag),
        .wr_data (pix_data),
        .rd_en   (fifo_rd_en),
        .rd_data (fifo_rd_data),
        .full    (fifo_full),
        .empty   (fifo_empty)
    );

    // State register.
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic: a pending trailer always takes the next free slot
    // before any pixel of the following frame.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (!fifo_empty && (gap_cnt_q == '0)) begin
                    state_d = SEND_PIX;
                end
            end
            SEND_PIX: begin
                state_d = (pix_cnt_q == CNT_LAST) ? WAIT_SUM : IDLE;
            end
            WAIT_SUM: begin
                if (gap_cnt_q == '0) begin
                    state_d = SEND_SUM;
                end
            end
            SEND_SUM: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Output and datapath logic. The output strobes are loaded on the edge
    // that enters a SEND state, so they are high during that state and a
    // pixel reaches tx_flag two cycles after its pix_flag.
    always_comb begin
        issue_pix    = (state_q == IDLE) && (state_d == SEND_PIX);
        issue_sum    = (state_q == WAIT_SUM) && (state_d == SEND_SUM);

        // The head byte was captured from the show-ahead port on entry; it
        // is popped while SEND_PIX is presented.
        fifo_rd_en   = (state_q == SEND_PIX);

        tx_flag_d    = issue_pix || issue_sum;
        frame_done_d = issue_sum;
        tx_data_d    = tx_data_q;
        if (issue_pix) begin
            tx_data_d = fifo_rd_data;
        end else if (issue_sum) begin
            tx_data_d = sum_q;
        end

        gap_cnt_d = gap_cnt_q;
        if (tx_flag_d) begin
            gap_cnt_d = GAP_LOAD;
        end else if (gap_cnt_q != '0) begin
            gap_cnt_d = gap_cnt_q - GAP_W'(1);
        end

        sum_d     = sum_q;
        pix_cnt_d = pix_cnt_q;
        if (state_q == SEND_PIX) begin
            sum_d     = sum_q + tx_data_q;
            pix_cnt_d = pix_cnt_q + CNT_W'(1);
        end else if (state_q == SEND_SUM) begin
            sum_d     = '0;
            pix_cnt_d = '0;
        end

        // A byte is lost only when the FIFO is full and nothing leaves in
        // the same cycle.
        overflow_d = overflow_q || (pix_flag && fifo_full && !fifo_rd_en);
    end

    // Datapath and output registers.
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            gap_cnt_q    <= '0;
            sum_q        <= '0;
            pix_cnt_q    <= '0;
            tx_data_q    <= '0;
            tx_flag_q    <= 1'b0;
            frame_done_q <= 1'b0;
            overflow_q   <= 1'b0;
        end else begin
            gap_cnt_q    <= gap_cnt_d;
            sum_q        <= sum_d;
            pix_cnt_q    <= pix_cnt_d;
            tx_data_q    <= tx_data_d;
            tx_flag_q    <= tx_flag_d;
            frame_done_q <= frame_done_d;
            overflow_q   <= overflow_d;
        end
    end

    assign tx_data    = tx_data_q;
    assign tx_flag    = tx_flag_q;
    assign frame_done = frame_done_q;
    assign overflow   = overflow_q;

endmodule

// File: tb/tb_uart_tx_sched.sv
// Randomised bench for uart_tx_sched against a transaction-level model of
// byte pacing, checksum trailers and FIFO admission.
module tb_uart_tx_sched;

    localparam int BC    = 10 * (50_000_000 / 10_000_000) + 2;
    localparam int DEPTH = 16;
    localparam int FRAME = 4;

    typedef struct {
        logic [7:0] data;
        int         wcyc;
    } ent_t;

    logic       sys_clk = 1'b0;
    logic       sys_rst = 1'b1;
    logic [7:0] pix_data = 8'h00;
    logic       pix_flag = 1'b0;
    logic [7:0] tx_data;
    logic       tx_flag;
    logic       frame_done;
    logic       overflow;

    int         chk_cnt = 0;
    int         err_cnt = 0;
    int         cyc = 0;

    ent_t       m_q[$];
    int         m_next = 0;
    bit         m_trl = 1'b0;
    logic [7:0] m_sum = 8'h00;
    int         m_cnt = 0;
    bit         m_ovf = 1'b0;
    bit         m_rst_prev = 1'b1;
    logic [7:0] last_trailer = 8'h00;

    uart_tx_sched dut (
        .sys_clk    (sys_clk),
        .sys_rst    (sys_rst),
        .pix_data   (pix_data),
        .pix_flag   (pix_flag),
        .tx_data    (tx_data),
        .tx_flag    (tx_flag),
        .frame_done (frame_done),
        .overflow   (overflow)
    );

    always #5 sys_clk = ~sys_clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        chk_cnt++;
        if (got !== exp) begin
            err_cnt++;
            $display("FAIL %s cyc=%0d got=%0h exp=%0h", tag, cyc, got, exp);
        end
    endtask

    // One clock cycle: check this cycle's outputs against the model, then
    // drive the inputs for this cycle and let the model absorb them.
    task automatic step(input bit rst, input bit flag, input logic [7:0] data);
        bit         e_flag;
        bit         e_done;
        logic [7:0] e_data;
        ent_t       e;
        e_flag = 1'b0;
        e_done = 1'b0;
        e_data = 8'h00;
        @(posedge sys_clk);
        #1;
        cyc++;
        if (cyc >= m_next) begin
            if (m_trl) begin
                e_flag = 1'b1;
                e_done = 1'b1;
                e_data = m_sum;
                m_sum  = 8'h00;
                m_trl  = 1'b0;
                m_next = cyc + BC;
            end else if (m_q.size() > 0 && m_q[0].wcyc <= cyc - 2) begin
                e = m_q.pop_front();
                e_flag = 1'b1;
                e_data = e.data;
                m_sum  = m_sum + e.data;
                m_cnt++;
                if (m_cnt == FRAME) begin
                    m_cnt = 0;
                    m_trl = 1'b1;
                end
                m_next = cyc + BC;
            end
        end
        check("tx_flag", 32'(tx_flag), 32'(e_flag));
        check("frame_done", 32'(frame_done), 32'(e_done));
        check("overflow", 32'(overflow), 32'(m_ovf));
        if (e_flag) begin
            check("tx_data", 32'(tx_data), 32'(e_data));
        end
        if (m_rst_prev) begin
            check("rst_tx_data", 32'(tx_data), 32'h0);
        end
        if (tx_flag) begin
            $display("tx cyc=%0d data=%02h trailer=%0b", cyc, tx_data, frame_done);
            if (frame_done) begin
                last_trailer = tx_data;
            end
        end

        sys_rst  = rst;
        pix_flag = flag;
        pix_data = data;
        if (rst) begin
            m_q.delete();
            m_next     = 0;
            m_trl      = 1'b0;
            m_sum      = 8'h00;
            m_cnt      = 0;
            m_ovf      = 1'b0;
            m_rst_prev = 1'b1;
        end else begin
            m_rst_prev = 1'b0;
            if (flag) begin
                if (m_q.size() < DEPTH) begin
                    m_q.push_back('{data, cyc});
                end else begin
                    m_ovf = 1'b1;
                end
            end
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            step(1'b0, 1'b0, 8'($urandom));
        end
    endtask

    task automatic burst(input int n);
        for (int i = 0; i < n; i++) begin
            step(1'b0, 1'b1, 8'($urandom));
        end
    endtask

    initial begin
        // Reset, then a single byte at cycle 10.
        repeat (3) step(1'b1, 1'b0, 8'h00);
        idle(6);
        step(1'b0, 1'b1, 8'h5A);
        idle(60);

        // Full frame with checksum wrap, then a byte landing in WAIT_SUM.
        step(1'b1, 1'b0, 8'h00);
        step(1'b0, 1'b1, 8'h10);
        step(1'b0, 1'b1, 8'h20);
        step(1'b0, 1'b1, 8'h30);
        step(1'b0, 1'b1, 8'hF5);
        idle(166);
        step(1'b0, 1'b1, 8'($urandom));
        idle(280);
        check("trailer_wrap", 32'(last_trailer), 32'h55);

        // 18 back-to-back bytes: the 18th is dropped.
        step(1'b1, 1'b0, 8'h00);
        burst(18);
        idle(1300);
        check("overflow_sticky", 32'(overflow), 32'h1);

        // Fill to full, then write exactly when a pop leaves a full FIFO.
        step(1'b1, 1'b0, 8'h00);
        burst(17);
        idle(37);
        step(1'b0, 1'b1, 8'($urandom));
        idle(1300);
        check("full_rw_no_ovf", 32'(overflow), 32'h0);

        // Reset after two of four bytes issued, then a fresh frame.
        step(1'b1, 1'b0, 8'h00);
        burst(4);
        idle(56);
        step(1'b1, 1'b0, 8'h00);
        burst(4);
        idle(300);

        // Random traffic.
        step(1'b1, 1'b0, 8'h00);
        for (int i = 0; i < 3000; i++) begin
            step(1'b0, ($urandom_range(0, 69) == 0), 8'($urandom));
        end
        idle(400);

        $display("End of test - %0d assertions evaluated, %0d failures", chk_cnt, err_cnt);
        $finish;
    end

endmodule
